// File: rtl/ad7606_frame_acq_if.sv
// Sample stream from the AD7606 frame acquisition block towards the DMA/FIFO path.
interface ad7606_frame_acq_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] m_data;
    logic [2:0]        m_ch;
    logic              m_last;
    logic              m_valid;
    logic              m_ready;

    modport master (output m_data, m_ch, m_last, m_valid, input m_ready);
    modport slave  (input m_data, m_ch, m_last, m_valid, output m_ready);
endinterface

// File: rtl/ad7606_frame_acq.sv
// AD7606 parallel-bus acquisition: rate-paced CONVST, per-word RD/CS, masked sample stream.
// Define AD7606_BUSY_TIMEOUT_EN to add the BUSY watchdog (abort + ADC reset, sticky Busy_Err).
//
// state     | meaning
// ----------+------------------------------------------------------
// INIT      | ADC RESET held high for RESET_CYC cycles
// IDLE      | waiting for Go && trig; latches OS and channel mask
// CONV      | CONVST low for CONVST_LOW_CYC cycles
// SETTLE    | fixed wait before BUSY is trusted
// WAIT_BUSY | waiting for synchronised BUSY low
// RD_LOW    | RD/CS low; data captured on the last cycle
// RD_HIGH   | RD/CS high between words
// DONE      | Conv_Done pulse
module ad7606_frame_acq #(
    parameter int NUM_CH         = 8,
    parameter int DATA_W         = 16,
    parameter int RATE_W         = 26,
    parameter int CONVST_LOW_CYC = 2,
    parameter int SETTLE_CYC     = 8,
    parameter int RD_LOW_CYC     = 4,
    parameter int RD_HIGH_CYC    = 6,
    parameter int RESET_CYC      = 10,
    parameter int BUSY_TMO       = 5000
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                Go,
    input  logic [RATE_W-1:0]   Speed_Set,
    input  logic [NUM_CH-1:0]   Ch_Mask,
    input  logic [2:0]          Os_Set,
    input  logic                Err_Clr,
    output logic                ad7606_convst_o,
    output logic                ad7606_rd_n_o,
    output logic                ad7606_cs_n_o,
    output logic                ad7606_reset_o,
    output logic [2:0]          ad7606_os_o,
    input  logic                ad7606_busy_i,
    input  logic [DATA_W-1:0]   ad7606_db_i,
    ad7606_frame_acq_if.master  strm,
    output logic                Conv_Done,
    output logic                Overrun,
    output logic                Trig_Miss,
    output logic                Busy_Err
);
    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_CONV, S_SETTLE, S_WAIT_BUSY, S_RD_LOW, S_RD_HIGH, S_DONE
    } state_t;

    // The sum of all hold lengths bounds the largest single load, so one width covers every timer value.
    localparam int TMR_W = $clog2(RESET_CYC + CONVST_LOW_CYC + SETTLE_CYC + RD_LOW_CYC
                                  + RD_HIGH_CYC + BUSY_TMO + 1);

    state_t            state, state_nxt;
    logic [TMR_W-1:0]  tmr, tmr_nxt;
    logic [2:0]        ch, ch_nxt;
    logic [RATE_W-1:0] cnt;
    logic              trig;
    logic [1:0]        busy_sync;
    logic              busy_s;
    logic [NUM_CH-1:0] mask_q;
    logic              start, cap;
    logic              emit, accept, ovr_set, miss_set, is_last;

    assign busy_s        = busy_sync[1];
    assign ad7606_cs_n_o = ad7606_rd_n_o;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt  <= '0;
            trig <= 1'b0;
        end else if (cnt >= Speed_Set) begin
            cnt  <= '0;
            trig <= 1'b1;
        end else begin
            cnt  <= cnt + RATE_W'(1);
            trig <= 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) busy_sync <= 2'b00;
        else          busy_sync <= {busy_sync[0], ad7606_busy_i};
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= S_INIT;
            tmr   <= TMR_W'(RESET_CYC - 1);
            ch    <= '0;
        end else begin
            state <= state_nxt;
            tmr   <= tmr_nxt;
            ch    <= ch_nxt;
        end
    end

`ifdef AD7606_BUSY_TIMEOUT_EN
    logic tmo_hit;
`endif

    always_comb begin
        state_nxt = state;
        tmr_nxt   = (tmr != '0) ? tmr - TMR_W'(1) : tmr;
        ch_nxt    = ch;
        start     = 1'b0;
        cap       = 1'b0;
`ifdef AD7606_BUSY_TIMEOUT_EN
        tmo_hit   = 1'b0;
`endif
        unique case (state)
            S_INIT: if (tmr == '0) state_nxt = S_IDLE;
            S_IDLE: if (Go && trig) begin
                start     = 1'b1;
                state_nxt = S_CONV;
                tmr_nxt   = TMR_W'(CONVST_LOW_CYC - 1);
            end
            S_CONV: if (tmr == '0) begin
                state_nxt = S_SETTLE;
                tmr_nxt   = TMR_W'(SETTLE_CYC - 1);
            end
            S_SETTLE: if (tmr == '0) begin
                state_nxt = S_WAIT_BUSY;
`ifdef AD7606_BUSY_TIMEOUT_EN
                tmr_nxt   = TMR_W'(BUSY_TMO - 1);
`endif
            end
            S_WAIT_BUSY: begin
                if (!busy_s) begin
                    state_nxt = S_RD_LOW;
                    ch_nxt    = '0;
                    tmr_nxt   = TMR_W'(RD_LOW_CYC - 1);
                end
`ifdef AD7606_BUSY_TIMEOUT_EN
                else if (tmr == '0) begin
                    tmo_hit   = 1'b1;
                    state_nxt = S_INIT;
                    tmr_nxt   = TMR_W'(RESET_CYC - 1);
                end
`endif
            end
            S_RD_LOW: if (tmr == '0) begin
                cap       = 1'b1;
                state_nxt = S_RD_HIGH;
                tmr_nxt   = TMR_W'(RD_HIGH_CYC - 1);
            end
            S_RD_HIGH: if (tmr == '0) begin
                if (ch < 3'(NUM_CH - 1)) begin
                    ch_nxt    = ch + 3'd1;
                    state_nxt = S_RD_LOW;
                    tmr_nxt   = TMR_W'(RD_LOW_CYC - 1);
                end else begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_INIT;
        endcase
    end

    // Pin strobes are registered from the next state so they line up with the state register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ad7606_convst_o <= 1'b1;
            ad7606_rd_n_o   <= 1'b1;
            ad7606_reset_o  <= 1'b1;
            Conv_Done       <= 1'b0;
            ad7606_os_o     <= 3'd0;
            mask_q          <= '0;
        end else begin
            ad7606_convst_o <= (state_nxt != S_CONV);
            ad7606_rd_n_o   <= (state_nxt != S_RD_LOW);
            ad7606_reset_o  <= (state_nxt == S_INIT);
            Conv_Done       <= (state_nxt == S_DONE);
            if (start) begin
                ad7606_os_o <= Os_Set;
                mask_q      <= Ch_Mask;
            end
        end
    end

    assign emit     = cap && mask_q[ch];
    assign accept   = strm.m_valid && strm.m_ready;
    assign ovr_set  = emit && strm.m_valid && !strm.m_ready;
    assign miss_set = trig && Go && (state != S_IDLE);
    assign is_last  = ((mask_q >> ch) == NUM_CH'(1));

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            strm.m_data  <= '0;
            strm.m_ch    <= '0;
            strm.m_last  <= 1'b0;
            strm.m_valid <= 1'b0;
        end else if (emit && !ovr_set) begin
            strm.m_data  <= ad7606_db_i;
            strm.m_ch    <= ch;
            strm.m_last  <= is_last;
            strm.m_valid <= 1'b1;
        end else if (accept) begin
            strm.m_valid <= 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Overrun   <= 1'b0;
            Trig_Miss <= 1'b0;
        end else begin
            if (ovr_set)      Overrun <= 1'b1;
            else if (Err_Clr) Overrun <= 1'b0;
            if (miss_set)     Trig_Miss <= 1'b1;
            else if (Err_Clr) Trig_Miss <= 1'b0;
        end
    end

`ifdef AD7606_BUSY_TIMEOUT_EN
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)     Busy_Err <= 1'b0;
        else if (tmo_hit) Busy_Err <= 1'b1;
        else if (Err_Clr) Busy_Err <= 1'b0;
    end
`else
    assign Busy_Err = 1'b0;
`endif
endmodule

// File: tb/tb_ad7606_frame_acq.sv
// Directed bench for ad7606_frame_acq with a simple AD7606 pin model (BUSY pulse, db = ch*0x1111).
module tb_ad7606_frame_acq;
    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Go = 1'b0;
    logic        Err_Clr = 1'b0;
    logic [25:0] Speed_Set = 26'd199;
    logic [7:0]  Ch_Mask = 8'hFF;
    logic [2:0]  Os_Set = 3'd0;
    logic        convst, rd_n, cs_n, adc_rst;
    logic [2:0]  os;
    logic        busy_q = 1'b0;
    logic        stuck = 1'b0;
    logic        busy;
    logic [15:0] db = 16'd0;
    logic        conv_done, overrun, trig_miss, busy_err;

    int checks = 0;
    int failures = 0;

    ad7606_frame_acq_if #(.DATA_W(16)) strm ();

    ad7606_frame_acq dut (
        .Clk(Clk), .Reset_n(Reset_n), .Go(Go), .Speed_Set(Speed_Set), .Ch_Mask(Ch_Mask),
        .Os_Set(Os_Set), .Err_Clr(Err_Clr), .ad7606_convst_o(convst), .ad7606_rd_n_o(rd_n),
        .ad7606_cs_n_o(cs_n), .ad7606_reset_o(adc_rst), .ad7606_os_o(os),
        .ad7606_busy_i(busy), .ad7606_db_i(db), .strm(strm), .Conv_Done(conv_done),
        .Overrun(overrun), .Trig_Miss(trig_miss), .Busy_Err(busy_err)
    );

    always #5 Clk = ~Clk;

    assign busy = busy_q | stuck;

    always @(posedge convst) begin
        #1 busy_q = 1'b1;
        repeat (40) @(posedge Clk);
        #1 busy_q = 1'b0;
    end

    int rd_idx = 0;
    always @(negedge rd_n or negedge convst) begin
        if (!convst) rd_idx = 0;
        else begin
            db = 16'(rd_idx * 16'h1111);
            rd_idx++;
        end
    end

    int cyc = 0, n_rd = 0, n_done = 0, n_conv = 0;
    int conv_t[$];
    logic [15:0] b_data[$];
    logic [2:0]  b_ch[$];
    logic        b_last[$];
    logic prev_rd = 1'b1, prev_cv = 1'b1;

    always @(negedge Clk) begin
        cyc++;
        if (prev_rd && !rd_n) n_rd++;
        if (prev_cv && !convst) begin
            n_conv++;
            conv_t.push_back(cyc);
        end
        if (conv_done) n_done++;
        if (strm.m_valid && strm.m_ready) begin
            b_data.push_back(strm.m_data);
            b_ch.push_back(strm.m_ch);
            b_last.push_back(strm.m_last);
        end
        prev_rd = rd_n;
        prev_cv = convst;
    end

    task automatic tick();
        @(negedge Clk);
        #1;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (conv_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_convst(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            tick();
            if (!convst) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int hi;
        strm.m_ready = 1'b1;
        repeat (3) tick();
        checks++;
        if ({convst, rd_n, cs_n, adc_rst} !== 4'b1111) begin
            failures++; $display("FAIL reset_pins got=%b want=1111", {convst, rd_n, cs_n, adc_rst});
        end
        checks++;
        if (os !== 3'd0) begin failures++; $display("FAIL reset_os got=%0d want=0", os); end
        checks++;
        if ({strm.m_valid, strm.m_last, strm.m_ch, strm.m_data} !== 21'd0) begin
            failures++; $display("FAIL reset_stream valid=%b last=%b ch=%0d data=%h want all 0",
                                 strm.m_valid, strm.m_last, strm.m_ch, strm.m_data);
        end
        checks++;
        if ({conv_done, overrun, trig_miss, busy_err} !== 4'b0000) begin
            failures++; $display("FAIL reset_flags got=%b want=0000", {conv_done, overrun, trig_miss, busy_err});
        end
        Reset_n = 1'b1;
        hi = 0;
        for (int i = 0; i < 30; i++) begin
            if (adc_rst) hi++;
            tick();
        end
        checks++;
        if (hi != 10) begin failures++; $display("FAIL reset_len got=%0d want=10", hi); end
    endtask

    task automatic test_stream();
        int bb, rb, cb, per;
        bit ok;
        bb = b_data.size(); rb = n_rd; cb = n_done;
        Go = 1'b1;
        wait_done(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL stream_done_timeout got=0 want=1"); end
        checks++;
        if (b_data.size() - bb != 8) begin
            failures++; $display("FAIL stream_beats got=%0d want=8", b_data.size() - bb);
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (b_data[bb+i] !== 16'(i * 16'h1111) || b_ch[bb+i] !== 3'(i) || b_last[bb+i] !== (i == 7)) begin
                    failures++;
                    $display("FAIL stream_beat%0d got=%h/%0d/%b want=%h/%0d/%b", i, b_data[bb+i], b_ch[bb+i],
                             b_last[bb+i], 16'(i * 16'h1111), i, (i == 7));
                end
            end
        end
        checks++;
        if (n_rd - rb != 8) begin failures++; $display("FAIL stream_rd_pulses got=%0d want=8", n_rd - rb); end
        checks++;
        if (n_done - cb != 1) begin failures++; $display("FAIL stream_done_cnt got=%0d want=1", n_done - cb); end
        wait_done(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL stream_done2_timeout got=0 want=1"); end
        per = (conv_t.size() >= 2) ? conv_t[conv_t.size()-1] - conv_t[conv_t.size()-2] : -1;
        checks++;
        if (per != 200) begin failures++; $display("FAIL stream_convst_period got=%0d want=200", per); end
        checks++;
        if (trig_miss !== 1'b0) begin failures++; $display("FAIL stream_trig_miss got=%b want=0", trig_miss); end
    endtask

    task automatic test_mask();
        int bb, rb;
        bit ok;
        Ch_Mask = 8'h24;
        bb = b_data.size(); rb = n_rd;
        wait_done(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL mask_done_timeout got=0 want=1"); end
        checks++;
        if (b_data.size() - bb != 2) begin
            failures++; $display("FAIL mask_beats got=%0d want=2", b_data.size() - bb);
        end else begin
            checks++;
            if (b_data[bb] !== 16'h2222 || b_ch[bb] !== 3'd2 || b_last[bb] !== 1'b0) begin
                failures++; $display("FAIL mask_beat0 got=%h/%0d/%b want=2222/2/0", b_data[bb], b_ch[bb], b_last[bb]);
            end
            checks++;
            if (b_data[bb+1] !== 16'h5555 || b_ch[bb+1] !== 3'd5 || b_last[bb+1] !== 1'b1) begin
                failures++; $display("FAIL mask_beat1 got=%h/%0d/%b want=5555/5/1", b_data[bb+1], b_ch[bb+1], b_last[bb+1]);
            end
        end
        checks++;
        if (n_rd - rb != 8) begin failures++; $display("FAIL mask_rd_pulses got=%0d want=8", n_rd - rb); end
    endtask

    task automatic test_overrun();
        int bb;
        bit ok;
        Ch_Mask = 8'hFF;
        strm.m_ready = 1'b0;
        bb = b_data.size();
        wait_done(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL ovr_done_timeout got=0 want=1"); end
        checks++;
        if (b_data.size() != bb) begin failures++; $display("FAIL ovr_beats got=%0d want=0", b_data.size() - bb); end
        checks++;
        if (strm.m_valid !== 1'b1 || strm.m_data !== 16'h0000 || strm.m_ch !== 3'd0) begin
            failures++; $display("FAIL ovr_held got=%b/%h/%0d want=1/0000/0", strm.m_valid, strm.m_data, strm.m_ch);
        end
        checks++;
        if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_flag got=%b want=1", overrun); end
        strm.m_ready = 1'b1;
        tick();
        checks++;
        if (strm.m_valid !== 1'b0) begin failures++; $display("FAIL ovr_drain got=%b want=0", strm.m_valid); end
        Err_Clr = 1'b1;
        tick();
        Err_Clr = 1'b0;
        checks++;
        if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_clear got=%b want=0", overrun); end
    endtask

    task automatic test_os();
        bit ok;
        wait_convst(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL os_convst_timeout got=0 want=1"); end
        Os_Set = 3'b011;
        repeat (5) tick();
        checks++;
        if (os !== 3'b000) begin failures++; $display("FAIL os_midframe got=%b want=000", os); end
        wait_done(ok);
        checks++;
        if (!ok || os !== 3'b000) begin failures++; $display("FAIL os_idle got=%b done=%b want=000/1", os, ok); end
        wait_convst(ok);
        checks++;
        if (!ok || os !== 3'b011) begin failures++; $display("FAIL os_next_frame got=%b start=%b want=011/1", os, ok); end
    endtask

    task automatic test_trig_miss();
        int bb, rb, vb;
        bit ok;
        wait_done(ok);
        checks++;
        if (!ok || trig_miss !== 1'b0) begin
            failures++; $display("FAIL miss_pre got=%b done=%b want=0/1", trig_miss, ok);
        end
        Speed_Set = 26'd20;
        for (int f = 0; f < 3; f++) begin
            bb = b_data.size(); rb = n_rd; vb = n_conv;
            wait_done(ok);
            checks++;
            if (!ok || b_data.size() - bb != 8 || n_rd - rb != 8 || n_conv - vb != 1) begin
                failures++;
                $display("FAIL miss_frame%0d got beats=%0d rd=%0d conv=%0d done=%b want 8/8/1/1",
                         f, b_data.size() - bb, n_rd - rb, n_conv - vb, ok);
            end else begin
                checks++;
                if (b_data[bb+7] !== 16'h7777 || b_last[bb+7] !== 1'b1) begin
                    failures++; $display("FAIL miss_last%0d got=%h/%b want=7777/1", f, b_data[bb+7], b_last[bb+7]);
                end
            end
        end
        checks++;
        if (trig_miss !== 1'b1) begin failures++; $display("FAIL miss_flag got=%b want=1", trig_miss); end
        Speed_Set = 26'd199;
    endtask

    task automatic test_busy_timeout();
        int bb;
        bit ok;
`ifdef AD7606_BUSY_TIMEOUT_EN
        int dc, hi;
        bit found;
        dc = n_done;
        stuck = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 8000; i++) begin
            tick();
            if (busy_err) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin failures++; $display("FAIL tmo_flag got=0 want=1"); end
        checks++;
        if (n_done != dc) begin failures++; $display("FAIL tmo_no_done got=%0d want=0", n_done - dc); end
        hi = 0;
        for (int i = 0; i < 30; i++) begin
            if (adc_rst) hi++;
            tick();
        end
        checks++;
        if (hi != 10) begin failures++; $display("FAIL tmo_reset_len got=%0d want=10", hi); end
        stuck = 1'b0;
        bb = b_data.size();
        wait_done(ok);
        checks++;
        if (!ok || b_data.size() - bb != 8) begin
            failures++; $display("FAIL tmo_resume got beats=%0d done=%b want=8/1", b_data.size() - bb, ok);
        end
`else
        bb = b_data.size();
        wait_done(ok);
        checks++;
        if (!ok || b_data.size() - bb != 8 || busy_err !== 1'b0) begin
            failures++; $display("FAIL busy_err_off got beats=%0d done=%b err=%b want=8/1/0",
                                 b_data.size() - bb, ok, busy_err);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_stream();
        test_mask();
        test_overrun();
        test_os();
        test_trig_miss();
        test_busy_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
